// File: rtl/flash_prog_pkg.sv
// Shared encodings for the flash programming sequencer: host commands, FSM states,
// JEDEC unlock addresses/command bytes and the per-command write-sequence ROM.
package flash_prog_pkg;

  typedef enum logic [1:0] {
    CMD_PROG  = 2'b00,
    CMD_ERASE = 2'b01,
    CMD_RESET = 2'b10,
    CMD_RSVD  = 2'b11
  } cmd_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_BUS,
    S_SETUP,
    S_WE_LOW,
    S_HOLD,
    S_NEXT,
    S_POLL_OE,
    S_POLL_GAP,
    S_DONE,
    S_ERR
  } state_e;

  typedef enum logic [1:0] {
    ASEL_ZERO,
    ASEL_555,
    ASEL_2AA,
    ASEL_TGT
  } asel_e;

  localparam logic [11:0] UNLOCK_A1 = 12'h555;
  localparam logic [11:0] UNLOCK_A2 = 12'h2AA;

  localparam logic [7:0] CB_UNLOCK1 = 8'hAA;
  localparam logic [7:0] CB_UNLOCK2 = 8'h55;
  localparam logic [7:0] CB_PROG    = 8'hA0;
  localparam logic [7:0] CB_ERASE   = 8'h80;
  localparam logic [7:0] CB_SECTOR  = 8'h30;
  localparam logic [7:0] CB_RESET   = 8'hF0;

  function automatic logic [2:0] seq_len(input cmd_e cmd);
    case (cmd)
      CMD_PROG:  return 3'd4;
      CMD_ERASE: return 3'd6;
      CMD_RESET: return 3'd1;
      default:   return 3'd0;
    endcase
  endfunction

  function automatic asel_e seq_asel(input cmd_e cmd, input logic [2:0] idx);
    asel_e a;
    a = ASEL_ZERO;
    case (cmd)
      CMD_PROG: begin
        case (idx)
          3'd0, 3'd2: a = ASEL_555;
          3'd1:       a = ASEL_2AA;
          default:    a = ASEL_TGT;
        endcase
      end
      CMD_ERASE: begin
        case (idx)
          3'd0, 3'd2, 3'd3: a = ASEL_555;
          3'd1, 3'd4:       a = ASEL_2AA;
          default:          a = ASEL_TGT;
        endcase
      end
      default: a = ASEL_ZERO;
    endcase
    return a;
  endfunction

  function automatic logic [7:0] seq_data(input cmd_e cmd, input logic [2:0] idx,
                                          input logic [7:0] wdata);
    logic [7:0] d;
    d = CB_RESET;
    case (cmd)
      CMD_PROG: begin
        case (idx)
          3'd0:    d = CB_UNLOCK1;
          3'd1:    d = CB_UNLOCK2;
          3'd2:    d = CB_PROG;
          default: d = wdata;
        endcase
      end
      CMD_ERASE: begin
        case (idx)
          3'd0, 3'd3: d = CB_UNLOCK1;
          3'd1, 3'd4: d = CB_UNLOCK2;
          3'd2:       d = CB_ERASE;
          default:    d = CB_SECTOR;
        endcase
      end
      default: d = CB_RESET;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/flash_prog_ctrl_gb_bus_sync.sv
// Synchronises the Game Boy bus strobes and flags the bus idle once all three
// have been high for IDLE_CYC consecutive clocks.
module gb_bus_sync #(
  parameter int IDLE_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic gb_cs_n,
  input  logic gb_rd_n,
  input  logic gb_wr_n,
  output logic gb_idle
);
  import flash_prog_pkg::*;

  localparam int CNT_W = $clog2(IDLE_CYC + 1);

  logic [2:0]       r_meta;
  logic [2:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_idle;
  logic             w_all_high;

  assign w_all_high = &r_sync;
  assign gb_idle    = r_idle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 3'b111;
      r_sync <= 3'b111;
      r_cnt  <= '0;
      r_idle <= 1'b0;
    end else begin
      r_meta <= {gb_cs_n, gb_rd_n, gb_wr_n};
      r_sync <= r_meta;
      if (!w_all_high) begin
        r_cnt  <= '0;
        r_idle <= 1'b0;
      end else if (r_cnt != CNT_W'(IDLE_CYC)) begin
        // counter parks at IDLE_CYC so gb_idle stays set while the bus is quiet
        r_cnt  <= r_cnt + 1'b1;
        r_idle <= (r_cnt == CNT_W'(IDLE_CYC - 1));
      end
    end
  end

endmodule

// File: rtl/flash_prog_ctrl.sv
// Flash bus sequencer/arbiter: runs JEDEC program/erase/reset sequences for the host
// port, polls DQ7 for completion and yields the bus whenever the Game Boy is active.
module flash_prog_ctrl #(
  parameter int ADDR_W      = 23,
  parameter int WE_PULSE    = 3,
  parameter int IDLE_CYC    = 4,
  parameter int POLL_OE     = 2,
  parameter int POLL_MAX    = 1 << 20,
  parameter int RESTART_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gb_cs_n,
  input  logic              gb_rd_n,
  input  logic              gb_wr_n,
  input  logic              host_req,
  input  logic [1:0]        host_cmd,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic              host_busy,
  output logic              host_ack,
  output logic              host_err,
  output logic              bus_grant,
  output logic [ADDR_W-1:0] fl_addr,
  output logic [7:0]        fl_dq_out,
  output logic              fl_dq_oe,
  input  logic [7:0]        fl_dq_in,
  output logic              fl_we_n,
  output logic              fl_oe_n,
  output logic              fl_ce_n
);
  import flash_prog_pkg::*;

  localparam int PH_MAX = (WE_PULSE > POLL_OE) ? WE_PULSE : POLL_OE;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int POLL_W = $clog2(POLL_MAX + 1);
  localparam int RST_W  = $clog2(RESTART_MAX + 2);

  state_e            r_state, w_state_nxt;
  logic [2:0]        r_idx, w_idx_nxt;
  logic [PH_W-1:0]   r_ph, w_ph_nxt;
  logic [POLL_W-1:0] r_poll, w_poll_nxt;
  logic [RST_W-1:0]  r_restart, w_restart_nxt;
  logic              r_polling, w_polling_nxt;

  cmd_e              r_cmd;
  logic [ADDR_W-1:0] r_tgt_addr;
  logic [7:0]        r_wdata;

  logic              r_we_n, r_oe_n, r_ce_n, r_dq_oe, r_grant;
  logic              r_busy, r_ack, r_err;
  logic [ADDR_W-1:0] r_fl_addr;
  logic [7:0]        r_fl_dq;

  logic              w_gb_idle;
  logic              w_accept;
  logic              w_last;
  logic              w_dq7_exp;
  asel_e             w_asel;
  logic [ADDR_W-1:0] w_seq_addr;
  logic              w_unused_dq;

  gb_bus_sync #(
    .IDLE_CYC (IDLE_CYC)
  ) u_gb_sync (
    .clk     (clk),
    .rst     (rst),
    .gb_cs_n (gb_cs_n),
    .gb_rd_n (gb_rd_n),
    .gb_wr_n (gb_wr_n),
    .gb_idle (w_gb_idle)
  );

  assign w_accept    = (r_state == S_IDLE) && host_req;
  assign w_last      = (r_idx == (seq_len(r_cmd) - 3'd1));
  assign w_dq7_exp   = (r_cmd == CMD_PROG) ? r_wdata[7] : 1'b1;
  assign w_unused_dq = ^fl_dq_in[6:0];

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_ph_nxt      = r_ph;
    w_poll_nxt    = r_poll;
    w_restart_nxt = r_restart;
    w_polling_nxt = r_polling;
    case (r_state)
      S_IDLE: begin
        if (host_req) begin
          w_idx_nxt     = '0;
          w_ph_nxt      = '0;
          w_poll_nxt    = '0;
          w_restart_nxt = '0;
          w_polling_nxt = 1'b0;
          w_state_nxt   = (cmd_e'(host_cmd) == CMD_RSVD) ? S_ERR : S_WAIT_BUS;
        end
      end
      S_WAIT_BUS: begin
        if (w_gb_idle) begin
          w_ph_nxt    = '0;
          w_state_nxt = r_polling ? S_POLL_OE : S_SETUP;
        end
      end
      S_SETUP: begin
        w_ph_nxt    = '0;
        w_state_nxt = S_WE_LOW;
      end
      S_WE_LOW: begin
        if (r_ph == PH_W'(WE_PULSE - 1)) w_state_nxt = S_HOLD;
        else                             w_ph_nxt    = r_ph + 1'b1;
      end
      S_HOLD: w_state_nxt = S_NEXT;
      S_NEXT: begin
        if (w_last) begin
          if (r_cmd == CMD_RESET) begin
            w_state_nxt = S_DONE;
          end else begin
            w_polling_nxt = 1'b1;
            w_ph_nxt      = '0;
            w_state_nxt   = w_gb_idle ? S_POLL_OE : S_WAIT_BUS;
          end
        end else if (!w_gb_idle) begin
          // an interrupted unlock sequence is invalid on the flash side; start it over
          w_idx_nxt     = '0;
          w_restart_nxt = r_restart + 1'b1;
          w_state_nxt   = (r_restart == RST_W'(RESTART_MAX)) ? S_ERR : S_WAIT_BUS;
        end else begin
          w_idx_nxt   = r_idx + 1'b1;
          w_state_nxt = S_SETUP;
        end
      end
      S_POLL_OE: begin
        if (r_ph == PH_W'(POLL_OE - 1)) begin
          if (fl_dq_in[7] == w_dq7_exp) begin
            w_state_nxt = S_DONE;
          end else begin
            w_poll_nxt  = r_poll + 1'b1;
            w_state_nxt = (r_poll == POLL_W'(POLL_MAX - 1)) ? S_ERR : S_POLL_GAP;
          end
        end else begin
          w_ph_nxt = r_ph + 1'b1;
        end
      end
      S_POLL_GAP: begin
        w_ph_nxt    = '0;
        w_state_nxt = w_gb_idle ? S_POLL_OE : S_WAIT_BUS;
      end
      S_DONE, S_ERR: w_state_nxt = S_IDLE;
      default:       w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_asel = seq_asel(r_cmd, w_idx_nxt);
    case (w_asel)
      ASEL_555: w_seq_addr = ADDR_W'(UNLOCK_A1);
      ASEL_2AA: w_seq_addr = ADDR_W'(UNLOCK_A2);
      ASEL_TGT: w_seq_addr = r_tgt_addr;
      default:  w_seq_addr = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_cmd      <= cmd_e'(host_cmd);
      r_tgt_addr <= host_addr;
      r_wdata    <= host_wdata;
    end
  end

  // Outputs are registered from the next state so every strobe is glitch-free
  // and falls back to its idle level the moment rst is asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_ph      <= '0;
      r_poll    <= '0;
      r_restart <= '0;
      r_polling <= 1'b0;
      r_we_n    <= 1'b1;
      r_oe_n    <= 1'b1;
      r_ce_n    <= 1'b1;
      r_dq_oe   <= 1'b0;
      r_grant   <= 1'b0;
      r_busy    <= 1'b0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_fl_addr <= '0;
      r_fl_dq   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_ph      <= w_ph_nxt;
      r_poll    <= w_poll_nxt;
      r_restart <= w_restart_nxt;
      r_polling <= w_polling_nxt;
      r_we_n    <= !(w_state_nxt == S_WE_LOW);
      r_oe_n    <= !(w_state_nxt == S_POLL_OE);
      r_ce_n    <= !(w_state_nxt inside {S_SETUP, S_WE_LOW, S_HOLD, S_POLL_OE});
      r_dq_oe   <= (w_state_nxt inside {S_SETUP, S_WE_LOW, S_HOLD});
      r_grant   <= (w_state_nxt inside {S_SETUP, S_WE_LOW, S_HOLD, S_NEXT,
                                        S_POLL_OE, S_POLL_GAP});
      r_busy    <= (w_state_nxt != S_IDLE);
      r_ack     <= (w_state_nxt inside {S_DONE, S_ERR});
      r_err     <= (w_state_nxt == S_ERR);
      if (w_state_nxt == S_SETUP) begin
        r_fl_addr <= w_seq_addr;
        r_fl_dq   <= seq_data(r_cmd, w_idx_nxt, r_wdata);
      end else if (w_state_nxt == S_POLL_OE) begin
        r_fl_addr <= r_tgt_addr;
      end
    end
  end

  assign fl_we_n   = r_we_n;
  assign fl_oe_n   = r_oe_n;
  assign fl_ce_n   = r_ce_n;
  assign fl_dq_oe  = r_dq_oe;
  assign bus_grant = r_grant;
  assign host_busy = r_busy;
  assign host_ack  = r_ack;
  assign host_err  = r_err;
  assign fl_addr   = r_fl_addr;
  assign fl_dq_out = r_fl_dq;

endmodule

// File: tb/tb_flash_prog_ctrl.sv
// Directed bench for flash_prog_ctrl: program/erase/reset sequences, GB preemption
// restarts, poll timeout, reserved command and asynchronous reset abort.
module tb_flash_prog_ctrl;

  logic        clk;
  logic        rst;
  logic        gb_cs_n, gb_rd_n, gb_wr_n;
  logic        host_req;
  logic [1:0]  host_cmd;
  logic [22:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_busy, host_ack, host_err, bus_grant;
  logic [22:0] fl_addr;
  logic [7:0]  fl_dq_out;
  logic        fl_dq_oe;
  logic [7:0]  fl_dq_in;
  logic        fl_we_n, fl_oe_n, fl_ce_n;

  int n_checks = 0;
  int n_fail   = 0;

  logic [30:0] wr_log[$];
  logic [30:0] exp_q[$];
  int          oe_falls    = 0;
  int          ce_falls    = 0;
  int          grant_rises = 0;
  int          ack_cnt     = 0;
  time         t_we_fall   = 0;
  int          we_width    = 0;

  int          rd_base = 0;
  int          fail_n  = 0;
  logic        good7   = 1'b0;
  int          wbase   = 0;
  int          gsnap   = 0;

  flash_prog_ctrl #(
    .ADDR_W      (23),
    .WE_PULSE    (3),
    .IDLE_CYC    (4),
    .POLL_OE     (2),
    .POLL_MAX    (16),
    .RESTART_MAX (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .gb_cs_n    (gb_cs_n),
    .gb_rd_n    (gb_rd_n),
    .gb_wr_n    (gb_wr_n),
    .host_req   (host_req),
    .host_cmd   (host_cmd),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_busy  (host_busy),
    .host_ack   (host_ack),
    .host_err   (host_err),
    .bus_grant  (bus_grant),
    .fl_addr    (fl_addr),
    .fl_dq_out  (fl_dq_out),
    .fl_dq_oe   (fl_dq_oe),
    .fl_dq_in   (fl_dq_in),
    .fl_we_n    (fl_we_n),
    .fl_oe_n    (fl_oe_n),
    .fl_ce_n    (fl_ce_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flash DQ7 model: the first fail_n reads of a test return the inverted status bit.
  assign fl_dq_in = {(((oe_falls - rd_base) <= fail_n) ? ~good7 : good7), 7'h15};

  always @(negedge fl_we_n) begin
    wr_log.push_back({fl_addr, fl_dq_out});
    t_we_fall = $time;
  end
  always @(posedge fl_we_n) we_width = int'($time - t_we_fall);
  always @(negedge fl_oe_n) oe_falls++;
  always @(negedge fl_ce_n) ce_falls++;
  always @(posedge bus_grant) grant_rises++;
  always @(posedge clk) if (host_ack) ack_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [30:0] mk(input logic [22:0] a, input logic [7:0] d);
    return {a, d};
  endfunction

  task automatic start_test(input logic g7, input int nfail);
    good7   = g7;
    fail_n  = nfail;
    rd_base = oe_falls;
    wbase   = wr_log.size();
    gsnap   = grant_rises;
  endtask

  task automatic issue(input logic [1:0] cmd, input logic [22:0] a, input logic [7:0] d);
    host_cmd   = cmd;
    host_addr  = a;
    host_wdata = d;
    host_req   = 1'b1;
    @(negedge clk);
    host_req   = 1'b0;
  endtask

  task automatic wait_ack(input int budget, output logic got, output logic err);
    got = 1'b0;
    err = 1'b0;
    for (int i = 0; i <= budget && !got; i++) begin
      if (host_ack) begin
        got = 1'b1;
        err = host_err;
      end else if (i < budget) begin
        @(negedge clk);
      end
    end
  endtask

  task automatic inject_after(input int target);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (wr_log.size() >= target) ok = 1'b1;
    end
    check("inject_wait", 32'(ok), 32'd1);
    gb_rd_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    gb_rd_n = 1'b1;
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwr"}, 32'(wr_log.size() - wbase), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      logic [30:0] obs;
      obs = ((wbase + i) < wr_log.size()) ? wr_log[wbase + i] : '1;
      check($sformatf("%s_w%0d", tag, i), 32'(obs), 32'(exp_q[i]));
    end
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic got, err, ok;
    int   asnap, csnap, wsnap;

    rst = 1'b1;
    gb_cs_n = 1'b1; gb_rd_n = 1'b1; gb_wr_n = 1'b1;
    host_req = 1'b0; host_cmd = 2'b00; host_addr = '0; host_wdata = '0;
    repeat (3) @(negedge clk);

    check("rst_ctrl", {24'd0, fl_we_n, fl_oe_n, fl_ce_n, fl_dq_oe,
                       bus_grant, host_busy, host_ack, host_err}, 32'h0000_00E0);
    check("rst_addr", 32'(fl_addr), 32'h0);
    check("rst_dq", 32'(fl_dq_out), 32'h0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Program 0x012345 <= 0x5A; DQ7 wrong five times, then right
    start_test(1'b0, 5);
    issue(2'b00, 23'h012345, 8'h5A);
    check("prog_busy", 32'(host_busy), 32'd1);
    wait_ack(400, got, err);
    check("prog_ack", 32'(got), 32'd1);
    check("prog_err", 32'(err), 32'd0);
    check("prog_busy_at_ack", 32'(host_busy), 32'd1);
    check("prog_grant_at_ack", 32'(bus_grant), 32'd0);
    exp_q.push_back(mk(23'h000555, 8'hAA));
    exp_q.push_back(mk(23'h0002AA, 8'h55));
    exp_q.push_back(mk(23'h000555, 8'hA0));
    exp_q.push_back(mk(23'h012345, 8'h5A));
    check_writes("prog");
    check("prog_polls", 32'(oe_falls - rd_base), 32'd6);
    check("prog_we_width", 32'(we_width), 32'd30);
    @(negedge clk);
    check("prog_busy_after", 32'(host_busy), 32'd0);
    check("prog_grant_after", 32'(bus_grant), 32'd0);
    repeat (2) @(negedge clk);

    // Sector erase 0x040000; DQ7 reads 0 twice then 1
    start_test(1'b1, 2);
    issue(2'b01, 23'h040000, 8'h00);
    wait_ack(400, got, err);
    check("erase_ack", 32'(got), 32'd1);
    check("erase_err", 32'(err), 32'd0);
    exp_q.push_back(mk(23'h000555, 8'hAA));
    exp_q.push_back(mk(23'h0002AA, 8'h55));
    exp_q.push_back(mk(23'h000555, 8'h80));
    exp_q.push_back(mk(23'h000555, 8'hAA));
    exp_q.push_back(mk(23'h0002AA, 8'h55));
    exp_q.push_back(mk(23'h040000, 8'h30));
    check_writes("erase");
    check("erase_polls", 32'(oe_falls - rd_base), 32'd3);
    repeat (2) @(negedge clk);

    // GB read between unlock cycles 2 and 3 forces one restart
    start_test(1'b1, 0);
    issue(2'b00, 23'h001000, 8'hC3);
    inject_after(wbase + 2);
    wait_ack(400, got, err);
    check("rst1_ack", 32'(got), 32'd1);
    check("rst1_err", 32'(err), 32'd0);
    exp_q.push_back(mk(23'h000555, 8'hAA));
    exp_q.push_back(mk(23'h0002AA, 8'h55));
    exp_q.push_back(mk(23'h000555, 8'hAA));
    exp_q.push_back(mk(23'h0002AA, 8'h55));
    exp_q.push_back(mk(23'h000555, 8'hA0));
    exp_q.push_back(mk(23'h001000, 8'hC3));
    check_writes("rst1");
    check("rst1_grants", 32'(grant_rises - gsnap), 32'd2);
    check("rst1_polls", 32'(oe_falls - rd_base), 32'd1);
    repeat (2) @(negedge clk);

    // Four GB interruptions exceed the restart budget
    start_test(1'b1, 0);
    issue(2'b00, 23'h002000, 8'h81);
    for (int p = 0; p < 4; p++) inject_after(wbase + 2 + 2 * p);
    wait_ack(400, got, err);
    check("rst4_ack", 32'(got), 32'd1);
    check("rst4_err", 32'(err), 32'd1);
    check("rst4_nwr", 32'(wr_log.size() - wbase), 32'd8);
    check("rst4_polls", 32'(oe_falls - rd_base), 32'd0);
    repeat (8) @(negedge clk);

    // DQ7 never matches: exactly POLL_MAX samples then error
    start_test(1'b0, 1000);
    issue(2'b00, 23'h003000, 8'h5A);
    wait_ack(600, got, err);
    check("tmo_ack", 32'(got), 32'd1);
    check("tmo_err", 32'(err), 32'd1);
    check("tmo_polls", 32'(oe_falls - rd_base), 32'd16);
    repeat (2) @(negedge clk);

    // Reserved command: error ack without touching the bus
    start_test(1'b0, 0);
    csnap = ce_falls;
    issue(2'b11, 23'h000001, 8'h01);
    wait_ack(1, got, err);
    check("rsvd_ack", 32'(got), 32'd1);
    check("rsvd_err", 32'(err), 32'd1);
    @(negedge clk);
    check("rsvd_busy_after", 32'(host_busy), 32'd0);
    check("rsvd_ce", 32'(ce_falls - csnap), 32'd0);
    check("rsvd_nwr", 32'(wr_log.size() - wbase), 32'd0);
    check("rsvd_grants", 32'(grant_rises - gsnap), 32'd0);
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of a WE pulse
    start_test(1'b0, 0);
    issue(2'b00, 23'h000100, 8'h11);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (!fl_we_n) ok = 1'b1;
    end
    check("arst_we_seen", 32'(ok), 32'd1);
    asnap = ack_cnt;
    rst = 1'b1;
    #1;
    check("arst_we_n", 32'(fl_we_n), 32'd1);
    check("arst_grant", 32'(bus_grant), 32'd0);
    check("arst_ce_n", 32'(fl_ce_n), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("arst_no_ack", 32'(ack_cnt - asnap), 32'd0);
    check("arst_busy", 32'(host_busy), 32'd0);

    // Reset command after the abort
    start_test(1'b0, 0);
    wsnap = wr_log.size();
    issue(2'b10, 23'h7FFFFF, 8'h00);
    wait_ack(200, got, err);
    check("rcmd_ack", 32'(got), 32'd1);
    check("rcmd_err", 32'(err), 32'd0);
    wbase = wsnap;
    exp_q.push_back(mk(23'h000000, 8'hF0));
    check_writes("rcmd");
    check("rcmd_polls", 32'(oe_falls - rd_base), 32'd0);
    @(negedge clk);
    check("rcmd_grant_after", 32'(bus_grant), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
